// File: rtl/trap_seq_ctrl_pkg.sv
// ============================================================================
// trap_seq_ctrl_pkg : shared CSR addresses, cause codes and SYSTEM encodings
// Revision 1.0
// ============================================================================
`default_nettype none

package trap_seq_ctrl_pkg;

   localparam int INT_BUS = 3;

   // int_req_i bit positions
   localparam int IRQ_MSI_BIT = 0;
   localparam int IRQ_MTI_BIT = 1;
   localparam int IRQ_MEI_BIT = 2;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;
   localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
   localparam logic [3:0] CODE_MEI         = 4'd11;
   localparam logic [3:0] CODE_MSI         = 4'd3;
   localparam logic [3:0] CODE_MTI         = 4'd7;

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

endpackage

`default_nettype wire

// File: rtl/trap_prio_enc.sv
// ============================================================================
// trap_prio_enc : picks ecall > ebreak > mret > MEI > MSI > MTI
// Revision 1.0
// ============================================================================
`default_nettype none

module trap_prio_enc
   import trap_seq_ctrl_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [INT_BUS-1:0] req,
   input  logic               sync_ecall,
   input  logic               sync_ebreak,
   input  logic               sync_mret,
   output logic               valid,
   output logic [XLEN-1:0]    cause,
   output logic               is_mret
);

   always_comb begin
      valid   = 1'b0;
      cause   = '0;
      is_mret = 1'b0;
      if (sync_ecall) begin
         valid      = 1'b1;
         cause[3:0] = CAUSE_ECALL_M;
      end else if (sync_ebreak) begin
         valid      = 1'b1;
         cause[3:0] = CAUSE_BREAKPOINT;
      end else if (sync_mret) begin
         valid   = 1'b1;
         is_mret = 1'b1;
      end else if (req[IRQ_MEI_BIT]) begin
         valid        = 1'b1;
         cause[3:0]   = CODE_MEI;
         cause[XLEN-1] = 1'b1;
      end else if (req[IRQ_MSI_BIT]) begin
         valid        = 1'b1;
         cause[3:0]   = CODE_MSI;
         cause[XLEN-1] = 1'b1;
      end else if (req[IRQ_MTI_BIT]) begin
         valid        = 1'b1;
         cause[3:0]   = CODE_MTI;
         cause[XLEN-1] = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/trap_seq_ctrl.sv
// ============================================================================
// trap_seq_ctrl : trap/mret CSR write sequencer and fetch redirect.
// Optional macro TRAP_VECTORED_EN enables vectored async trap targets.
// Revision 1.0
// ============================================================================
`default_nettype none

module trap_seq_ctrl
   import trap_seq_ctrl_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int CSR_AW = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INT_BUS-1:0] int_req_i,
   input  logic [31:0]        inst_i,
   input  logic [XLEN-1:0]    inst_addr_i,
   input  logic               jump_flag_i,
   input  logic [XLEN-1:0]    jump_addr_i,
   input  logic [XLEN-1:0]    csr_mtvec_i,
   input  logic [XLEN-1:0]    csr_mepc_i,
   input  logic [XLEN-1:0]    csr_mstatus_i,
   input  logic [XLEN-1:0]    csr_mie_i,
   output logic               hold_flag_o,
   output logic               csr_we_o,
   output logic [CSR_AW-1:0]  csr_waddr_o,
   output logic [XLEN-1:0]    csr_wdata_o,
   output logic               int_flag_o,
   output logic [XLEN-1:0]    int_addr_o
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_W_MEPC  = 3'd1;
   localparam logic [2:0] S_W_CAUSE = 3'd2;
   localparam logic [2:0] S_W_MSTAT = 3'd3;
   localparam logic [2:0] S_JUMP    = 3'd4;
   localparam logic [2:0] S_M_MSTAT = 3'd5;
   localparam logic [2:0] S_M_JUMP  = 3'd6;

   logic [2:0]         r_state;
   logic [XLEN-1:0]    r_cause;
   logic [XLEN-1:0]    r_epc;
   logic [XLEN-1:0]    r_target;

   logic [INT_BUS-1:0] w_irq_en;
   logic [INT_BUS-1:0] w_masked_req;
   logic               w_valid;
   logic [XLEN-1:0]    w_cause;
   logic               w_is_mret;
   logic               w_async;
   logic [XLEN-1:0]    w_epc;
   logic [XLEN-1:0]    w_base;
   logic [XLEN-1:0]    w_target;
   logic               w_trigger;
   logic               unused_ok;

   function automatic logic [XLEN-1:0] f_trap_mstatus(input logic [XLEN-1:0] s);
      logic [XLEN-1:0] r;
      r                               = s;
      r[MSTATUS_MPIE]                 = s[MSTATUS_MIE];
      r[MSTATUS_MIE]                  = 1'b0;
      r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return r;
   endfunction

   function automatic logic [XLEN-1:0] f_mret_mstatus(input logic [XLEN-1:0] s);
      logic [XLEN-1:0] r;
      r                               = s;
      r[MSTATUS_MIE]                  = s[MSTATUS_MPIE];
      r[MSTATUS_MPIE]                 = 1'b1;
      r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return r;
   endfunction

   // Enable vector ordered like int_req_i: {MEIE, MTIE, MSIE}
   assign w_irq_en     = {csr_mie_i[11], csr_mie_i[7], csr_mie_i[3]};
   assign w_masked_req = int_req_i & w_irq_en & {INT_BUS{csr_mstatus_i[MSTATUS_MIE]}};

   trap_prio_enc #(
      .XLEN (XLEN)
   ) u_prio (
      .req         (w_masked_req),
      .sync_ecall  (inst_i == INST_ECALL),
      .sync_ebreak (inst_i == INST_EBREAK),
      .sync_mret   (inst_i == INST_MRET),
      .valid       (w_valid),
      .cause       (w_cause),
      .is_mret     (w_is_mret)
   );

   assign w_async = w_cause[XLEN-1];
   assign w_epc   = (w_async && jump_flag_i) ? jump_addr_i : inst_addr_i;
   assign w_base  = {csr_mtvec_i[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
   assign w_target = (w_async && (csr_mtvec_i[1:0] == 2'b01))
                   ? w_base + ({{(XLEN-4){1'b0}}, w_cause[3:0]} << 2)
                   : w_base;
`else
   assign w_target = w_base;
`endif

   assign w_trigger = (r_state == S_IDLE) && w_valid;
   assign unused_ok = ^{csr_mie_i, csr_mtvec_i[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cause  <= '0;
         r_epc    <= '0;
         r_target <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_valid) begin
                  if (w_is_mret) begin
                     r_state <= S_M_MSTAT;
                  end else begin
                     r_state  <= S_W_MEPC;
                     r_cause  <= w_cause;
                     r_epc    <= w_epc;
                     r_target <= w_target;
                  end
               end
            end
            S_W_MEPC:  r_state <= S_W_CAUSE;
            S_W_CAUSE: r_state <= S_W_MSTAT;
            S_W_MSTAT: r_state <= S_JUMP;
            S_JUMP:    r_state <= S_IDLE;
            S_M_MSTAT: r_state <= S_M_JUMP;
            S_M_JUMP:  r_state <= S_IDLE;
            default:   r_state <= S_IDLE;
         endcase
      end
   end

   // Reset forces hold low even if a trigger is sitting in ID.
   assign hold_flag_o = rst_n && (w_trigger || (r_state != S_IDLE));

   always_comb begin
      csr_we_o    = 1'b0;
      csr_waddr_o = '0;
      csr_wdata_o = '0;
      int_flag_o  = 1'b0;
      int_addr_o  = '0;
      case (r_state)
         S_W_MEPC: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_AW'(CSR_MEPC);
            csr_wdata_o = r_epc;
         end
         S_W_CAUSE: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_AW'(CSR_MCAUSE);
            csr_wdata_o = r_cause;
         end
         S_W_MSTAT: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_AW'(CSR_MSTATUS);
            csr_wdata_o = f_trap_mstatus(csr_mstatus_i);
         end
         S_JUMP: begin
            int_flag_o = 1'b1;
            int_addr_o = r_target;
         end
         S_M_MSTAT: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_AW'(CSR_MSTATUS);
            csr_wdata_o = f_mret_mstatus(csr_mstatus_i);
         end
         S_M_JUMP: begin
            int_flag_o = 1'b1;
            int_addr_o = csr_mepc_i;
         end
         default: begin
            csr_we_o = 1'b0;
         end
      endcase
   end

endmodule

`default_nettype wire
